// File: rtl/id_regfile.sv
// Decode-stage register file: 32x32 with 1 write / 2 read ports and a pending-write scoreboard.
// Reads are combinational with optional write-through; stall flags operands awaiting writeback.
module id_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_en,
  input  logic [4:0]  reg_write_dest,
  input  logic [31:0] reg_write_data,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        use1,
  input  logic        use2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        pend_set_en,
  input  logic [4:0]  pend_set_dest,
  output logic        busy1,
  output logic        busy2,
  output logic        stall
);

  logic [31:0] regs [1:31];
  logic [31:1] pend;

  logic wr_vld;
  logic set_vld;
  logic fwd1;
  logic fwd2;

  assign wr_vld  = reg_write_en && (reg_write_dest != 5'd0);
  assign set_vld = pend_set_en && (pend_set_dest != 5'd0);

  // Forwarding only ever targets a nonzero register, so $0 stays hard-wired to 0.
  assign fwd1 = BYPASS && wr_vld && (reg_write_dest == raddr1);
  assign fwd2 = BYPASS && wr_vld && (reg_write_dest == raddr2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (wr_vld) begin
        regs[reg_write_dest] <= reg_write_data;
        pend[reg_write_dest] <= 1'b0;
      end
      // Issued after the clear so a new long-latency op on the same register wins.
      if (set_vld) begin
        pend[pend_set_dest] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) begin
      rdata1 = fwd1 ? reg_write_data : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) begin
      rdata2 = fwd2 ? reg_write_data : regs[raddr2];
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (raddr1 != 5'd0) begin
      busy1 = pend[raddr1] && !fwd1;
    end
    if (raddr2 != 5'd0) begin
      busy2 = pend[raddr2] && !fwd2;
    end
  end

  assign stall = (busy1 && use1) || (busy2 && use2);

endmodule

// File: doc/id_regfile.md
# id_regfile

General-purpose register file for the decode stage: 32 x 32-bit registers with one write port and two read ports, plus a per-register pending scoreboard. The write port accepts the `reg_write_en` / `reg_write_dest` / `reg_write_data` triple driven by the writeback stage, including link writes to $31. Read ports use write-through bypass, so decode sees a value in the same cycle it is written back. The scoreboard tracks destinations of issued long-latency operations (loads, multiply/divide) and raises `stall` while decode needs an operand that has not yet been written back.

## Interface
- `BYPASS`, default 1: 1 enables same-cycle write-to-read forwarding; 0 makes reads return only the stored array value.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `reg_write_en`  in  1  write strobe from writeback.
- `reg_write_dest`  in  5  register written.
- `reg_write_data`  in  32  value written.
- `raddr1`, `raddr2`  in  5 each  read addresses (rs, rt).
- `use1`, `use2`  in  1 each  decode actually consumes operand 1 / 2 this cycle.
- `rdata1`, `rdata2`  out  32 each  read data, combinational.
- `pend_set_en`  in  1  issue of a long-latency op whose result returns via writeback.
- `pend_set_dest`  in  5  destination of that op.
- `busy1`, `busy2`  out  1 each  the operand's register is pending and its value is not available this cycle.
- `stall`  out  1  `(busy1 & use1) | (busy2 & use2)`.

## Operation
- State:
  - `regs[1..31]`, 32 bits each. Register 0 is not stored.
  - `pend[1..31]`, 1 bit each.
- Write: on a rising edge with `reg_write_en=1` and `reg_write_dest!=0`, set `regs[dest] <= reg_write_data`. Writes to $0 are discarded.
- Read, for each port independently:
  - Address 0 returns 0.
  - If `BYPASS=1`, `reg_write_en=1`, and `reg_write_dest==raddr!=0`, return `reg_write_data`.
  - Otherwise return `regs[raddr]`.
- Pending clear: on a rising edge with `reg_write_en=1` and `dest!=0`, clear `pend[dest]`. A write to a register that is not pending is legal and leaves `pend` at 0.
- Pending set: on a rising edge with `pend_set_en=1` and `pend_set_dest!=0`, set `pend[pend_set_dest]`.
- Set and clear on the same register in the same edge: set wins, because the new issue supersedes the returning result.
- busy:
  - `busy_n = pend[raddr_n] & (raddr_n!=0) & ~(BYPASS & reg_write_en & reg_write_dest==raddr_n)`.
  - With `BYPASS=0`, a register still reads busy in its writeback cycle; `busy` drops in the next cycle.
- The scoreboard is a single bit per register, not a counter. The pipeline guarantees at most one outstanding long-latency write per register. Two sets without an intervening clear are not an error; one writeback clears the bit.

## Timing
- Reset (`rst=0`, asynchronous): all `regs` = 0 and all `pend` = 0 immediately, independent of `clk`.
  - Outputs during reset: `rdata1`/`rdata2` = 0 unless the bypass is active, `busy1`/`busy2` = 0, `stall` = 0.
  - Reset asserted mid-operation discards all pending marks. No write lands on the edge where `rst=0`.
- Release of reset is synchronous to the next rising edge; the first update occurs on that edge.
- Write latency: 1 edge into the array. With `BYPASS=1`, effective read latency is 0 cycles.
- Pending set is visible on `busy`/`stall` in the cycle after `pend_set_en`, never in the same cycle.
- `rdata*`, `busy*` and `stall` are purely combinational from the inputs and the state; there are no registered outputs.
- Both read ports may address the same register, and each gets an identical result.

## Test plan
- Reset then read: assert `rst=0` mid-cycle after writing `regs[5]=32'hDEADBEEF`. With `raddr1=5`, `rdata1` must be 0 at once, and `busy1=0`, `stall=0`.
- Write/read and $0:
  - Write 32'h12345678 to r7, then read r7 on both ports; both return 32'h12345678.
  - Write 32'hFFFFFFFF to r0; reading r0 returns 0.
- Bypass:
  - `reg_write_en=1`, dest=31, data=32'h00400008, `raddr2=31`, same cycle: `rdata2=32'h00400008`.
  - Repeat with `BYPASS=0`: `rdata2` shows the old value in that cycle and the new value in the next cycle.
- Scoreboard:
  - Pulse `pend_set_en` with dest=9. Next cycle, `raddr1=9` with `use1=1` gives `busy1=1`, `stall=1`. With `use1=0` it gives `stall=0`.
  - Writeback to r9: in that cycle `busy1=0`, `stall=0`, `rdata1` = written data.
  - The following cycle: `pend[9]=0`.
- Simultaneous set and clear on r4 in the same edge: the next cycle `busy` for r4 = 1. Setting r0 pending never produces busy.
- Back-to-back: set r3 pending, then writeback r3 while setting r3 pending again on the same edge. r3 stays busy until a second writeback, after which `busy=0`.
